// File: rtl/fft16_pkg.sv
// rtl/fft16_pkg.sv - shared constants, state encoding and bus slicing helper for the FFT16 sequencer
package fft16_pkg;

  localparam int N_DEF       = 16;
  localparam int Q_DEF       = 8;
  localparam int STAGES_DEF  = 4;
  localparam int TIMEOUT_DEF = 64;
  localparam int POINTS      = 1 << STAGES_DEF;
  localparam int CPLX_W      = 2 * N_DEF;

  typedef enum logic [2:0] {
    IDLE,
    LOAD,
    START,
    RUN,
    UNLOAD
  } state_e;

  // Low bit of bin k on a flat bus of w-bit complex bins.
  function automatic int bin_lo(input int k, input int w);
    return k * w;
  endfunction

endpackage

// File: rtl/fft16_symbol_sequencer_bin_buffer.sv
// rtl/fft16_symbol_sequencer_bin_buffer.sv - 16-bin complex register file with single-bin write, zero-fill, bulk load and registered read
module fft16_bin_buffer
  import fft16_pkg::*;
#(
  parameter int W   = CPLX_W,
  parameter int PTS = POINTS,
  parameter int IW  = $clog2(PTS)
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              wr_en,
  input  logic [IW-1:0]     wr_idx,
  input  logic [W-1:0]      wr_data,
  input  logic              zero_fill,
  input  logic              ld_en,
  input  logic [PTS*W-1:0]  ld_data,
  input  logic [IW-1:0]     rd_idx,
  output logic [W-1:0]      rd_data,
  output logic [PTS*W-1:0]  flat
);

  logic [W-1:0] regs_q [PTS];
  logic [W-1:0] regs_d [PTS];
  logic [W-1:0] rd_data_q, rd_data_d;

  // Next contents: bulk load, then single-bin write with optional clearing of all higher bins.
  // The read mux looks at the next contents so a bin loaded this cycle is readable next cycle.
  always_comb begin
    for (int k = 0; k < PTS; k++) begin
      regs_d[k] = regs_q[k];
      if (ld_en) regs_d[k] = ld_data[bin_lo(k, W) +: W];
      if (wr_en) begin
        if (IW'(k) == wr_idx) regs_d[k] = wr_data;
        else if (zero_fill && (IW'(k) > wr_idx)) regs_d[k] = '0;
      end
    end
    rd_data_d = regs_d[rd_idx];
  end

  // Storage and registered read port.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      for (int k = 0; k < PTS; k++) regs_q[k] <= '0;
      rd_data_q <= '0;
    end else begin
      for (int k = 0; k < PTS; k++) regs_q[k] <= regs_d[k];
      rd_data_q <= rd_data_d;
    end
  end

  // Flatten storage onto the bus, bin k at [k*W +: W].
  always_comb begin
    flat = '0;
    for (int k = 0; k < PTS; k++) flat[bin_lo(k, W) +: W] = regs_q[k];
  end

  assign rd_data = rd_data_q;

endmodule

// File: rtl/fft16_symbol_sequencer.sv
// rtl/fft16_symbol_sequencer.sv - collects one OFDM symbol, runs FFT16 once, streams the 16 output bins
module fft16_symbol_sequencer
  import fft16_pkg::*;
#(
  parameter int N       = N_DEF,
  parameter int Q       = Q_DEF,
  parameter int STAGES  = STAGES_DEF,
  parameter int TIMEOUT = TIMEOUT_DEF
) (
  input  logic                            i_clk,
  input  logic                            i_rst,
  input  logic                            i_s_valid,
  output logic                            o_s_ready,
  input  logic [2*N-1:0]                  i_s_data,
  input  logic                            i_s_last,
  output logic [(1<<STAGES)*2*N-1:0]      o_fft_in,
  output logic                            o_fft_start,
  input  logic                            i_fft_done,
  input  logic [(1<<STAGES)*2*N-1:0]      i_fft_out,
  output logic                            o_m_valid,
  input  logic                            i_m_ready,
  output logic [2*N-1:0]                  o_m_data,
  output logic [STAGES-1:0]               o_m_idx,
  output logic                            o_m_last,
  output logic                            o_busy,
  output logic                            o_err_timeout
);

  localparam int PTS = 1 << STAGES;
  localparam int W   = 2 * N;
  localparam int CW  = $clog2(TIMEOUT);

  state_e              state_q, state_d;
  logic [STAGES-1:0]   wr_idx_q, wr_idx_d;
  logic [STAGES-1:0]   rd_idx_q, rd_idx_d;
  logic [CW-1:0]       cnt_q, cnt_d;
  logic                err_q, err_d;
  logic                s_acc, run_done, run_expire, end_of_load, last_bin_taken;

  assign s_acc          = i_s_valid && o_s_ready;
  assign run_done       = (state_q == RUN) && i_fft_done;
  assign run_expire     = (state_q == RUN) && !i_fft_done && (cnt_q == CW'(TIMEOUT - 1));
  assign end_of_load    = s_acc && (i_s_last || (wr_idx_q == STAGES'(PTS - 1)));
  assign last_bin_taken = (state_q == UNLOAD) && i_m_ready && (rd_idx_q == STAGES'(PTS - 1));

  // State register.
  always_ff @(posedge i_clk or posedge i_rst) begin
    if (i_rst) state_q <= IDLE;
    else       state_q <= state_d;
  end

  // Next-state logic; a done pulse outside RUN has no effect.
  always_comb begin
    state_d = state_q;
    case (state_q)
      IDLE:    if (s_acc) state_d = i_s_last ? START : LOAD;
      LOAD:    if (end_of_load) state_d = START;
      START:   state_d = RUN;
      RUN:     if (run_done) state_d = UNLOAD;
               else if (run_expire) state_d = IDLE;
      UNLOAD:  if (last_bin_taken) state_d = IDLE;
      default: state_d = IDLE;
    endcase
  end

  // State-decoded outputs.
  always_comb begin
    o_s_ready     = (state_q == IDLE) || (state_q == LOAD);
    o_fft_start   = (state_q == START);
    o_m_valid     = (state_q == UNLOAD);
    o_busy        = (state_q != IDLE);
    o_m_idx       = rd_idx_q;
    o_m_last      = (state_q == UNLOAD) && (rd_idx_q == STAGES'(PTS - 1));
    o_err_timeout = err_q;
  end

  // Write index, read index, timeout counter and timeout pulse.
  // wr_idx returns to 0 in START so IDLE always writes bin 0.
  always_comb begin
    wr_idx_d = wr_idx_q;
    rd_idx_d = rd_idx_q;
    cnt_d    = cnt_q;
    err_d    = run_expire;
    case (state_q)
      IDLE:    wr_idx_d = s_acc ? STAGES'(1) : '0;
      LOAD:    if (s_acc) wr_idx_d = wr_idx_q + STAGES'(1);
      START:   begin wr_idx_d = '0; cnt_d = '0; end
      RUN:     if (run_done) rd_idx_d = '0;
               else if (!run_expire) cnt_d = cnt_q + CW'(1);
      UNLOAD:  if (i_m_ready) rd_idx_d = rd_idx_q + STAGES'(1);
      default: ;
    endcase
  end

  // Datapath counters and registered timeout pulse.
  always_ff @(posedge i_clk or posedge i_rst) begin
    if (i_rst) begin
      wr_idx_q <= '0;
      rd_idx_q <= '0;
      cnt_q    <= '0;
      err_q    <= 1'b0;
    end else begin
      wr_idx_q <= wr_idx_d;
      rd_idx_q <= rd_idx_d;
      cnt_q    <= cnt_d;
      err_q    <= err_d;
    end
  end

  // Input hold registers: the last beat clears every bin above it.
  fft16_bin_buffer #(.W(W), .PTS(PTS), .IW(STAGES)) u_in_buf (
    .clk       (i_clk),
    .rst       (i_rst),
    .wr_en     (s_acc),
    .wr_idx    (wr_idx_q),
    .wr_data   (i_s_data),
    .zero_fill (i_s_last),
    .ld_en     (1'b0),
    .ld_data   ('0),
    .rd_idx    ('0),
    .rd_data   (),
    .flat      (o_fft_in)
  );

  // Output capture: loaded on the done pulse, read port follows the next read index.
  fft16_bin_buffer #(.W(W), .PTS(PTS), .IW(STAGES)) u_out_buf (
    .clk       (i_clk),
    .rst       (i_rst),
    .wr_en     (1'b0),
    .wr_idx    ('0),
    .wr_data   ('0),
    .zero_fill (1'b0),
    .ld_en     (run_done),
    .ld_data   (i_fft_out),
    .rd_idx    (rd_idx_d),
    .rd_data   (o_m_data),
    .flat      ()
  );

endmodule

// File: tb/tb_fft16_symbol_sequencer.sv
// tb/tb_fft16_symbol_sequencer.sv - self-checking bench for fft16_symbol_sequencer
module tb_fft16_symbol_sequencer;

  typedef struct packed {
    logic [31:0] data;
    logic [3:0]  idx;
    logic        last;
  } exp_t;

  typedef struct {
    int nb;
    bit lst;
    int base;
    int rmode;
    int delay;
    bit hang;
    int exp_nout;
    bit exp_to;
  } vec_t;

  logic         clk = 1'b0;
  logic         i_rst;
  logic         i_s_valid, i_s_last, i_fft_done, i_m_ready;
  logic [31:0]  i_s_data;
  logic [511:0] i_fft_out, o_fft_in, model_out, stray_out;
  logic         model_done, stray_done;
  logic         o_s_ready, o_fft_start, o_m_valid, o_m_last, o_busy, o_err_timeout;
  logic [31:0]  o_m_data;
  logic [3:0]   o_m_idx;

  int   n_tests = 0, n_fail = 0, cyc = 0;
  int   out_cnt = 0, start_cnt = 0, sym = 0;
  int   done_cyc = 0, last_hs_cyc = 0, first_acc_cyc = 0, sym_start_cyc = 0;
  int   done_delay = 5, ready_mode = 0, stall_cnt = 0;
  bit   hang = 0, stalled = 0;
  exp_t exp_q[$];
  exp_t mon_e;
  bit   prev_valid = 0, prev_stall = 0;
  logic [31:0] prev_data;
  logic [3:0]  prev_idx;
  vec_t vecs[6];

  assign i_fft_done = model_done | stray_done;
  assign i_fft_out  = model_done ? model_out : stray_out;

  fft16_symbol_sequencer dut (
    .i_clk         (clk),
    .i_rst         (i_rst),
    .i_s_valid     (i_s_valid),
    .o_s_ready     (o_s_ready),
    .i_s_data      (i_s_data),
    .i_s_last      (i_s_last),
    .o_fft_in      (o_fft_in),
    .o_fft_start   (o_fft_start),
    .i_fft_done    (i_fft_done),
    .i_fft_out     (i_fft_out),
    .o_m_valid     (o_m_valid),
    .i_m_ready     (i_m_ready),
    .o_m_data      (o_m_data),
    .o_m_idx       (o_m_idx),
    .o_m_last      (o_m_last),
    .o_busy        (o_busy),
    .o_err_timeout (o_err_timeout)
  );

  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  task automatic check(input string name, input logic [511:0] act, input logic [511:0] req);
    n_tests++;
    if (act !== req) begin
      n_fail++;
      $display("FAIL %s: got %0h required %0h", name, act, req);
    end
  endtask

  task automatic bound_fail(input string name);
    n_tests++;
    n_fail++;
    $display("FAIL %s: wait bound expired at cycle %0d", name, cyc);
  endtask

  function automatic logic [31:0] pat(input int s, input int k);
    logic [15:0] v;
    v = 16'(s * 37 + k * 3 + 1);
    return {v, v ^ 16'hA5A5};
  endfunction

  // FFT model: done pulse done_delay cycles after start, expected bins queued at that moment.
  initial begin
    model_done = 1'b0;
    model_out  = '0;
    forever begin
      @(negedge clk);
      if (o_fft_start && !i_rst) begin
        start_cnt++;
        if (!hang) begin
          repeat (done_delay) @(posedge clk);
          #1;
          for (int k = 0; k < 16; k++) begin
            model_out[k*32 +: 32] = pat(sym, k);
            exp_q.push_back('{data: pat(sym, k), idx: 4'(k), last: (k == 15)});
          end
          done_cyc   = cyc;
          model_done = 1'b1;
          @(posedge clk);
          #1;
          model_done = 1'b0;
          sym++;
        end
      end
    end
  end

  // Downstream ready: always 1, or 1010... with a 4-cycle hold-low on bin 7.
  initial begin
    i_m_ready = 1'b1;
    forever begin
      @(posedge clk);
      #1;
      if (ready_mode == 0) i_m_ready = 1'b1;
      else if (stall_cnt > 0) begin
        i_m_ready = 1'b0;
        stall_cnt--;
      end else if (o_m_valid && o_m_idx == 4'd7 && !stalled) begin
        stalled   = 1'b1;
        stall_cnt = 3;
        i_m_ready = 1'b0;
      end else i_m_ready = ~i_m_ready;
    end
  end

  // Output monitor: pops the scoreboard on every handshake, checks stability while stalled.
  initial begin
    forever begin
      @(negedge clk);
      if (i_rst) begin
        prev_valid = 1'b0;
        prev_stall = 1'b0;
      end else begin
        if (o_m_valid) begin
          check("s_ready_in_unload", o_s_ready, 1'b0);
          if (prev_stall) begin
            check("stall_data", o_m_data, prev_data);
            check("stall_idx", o_m_idx, prev_idx);
          end
          if (!prev_valid) check("first_out_latency", cyc, done_cyc + 1);
          if (i_m_ready) begin
            if (exp_q.size() == 0) begin
              n_tests++;
              n_fail++;
              $display("FAIL out_unexpected: got bin idx %0d, required no output", o_m_idx);
            end else begin
              mon_e = exp_q.pop_front();
              check("out_data", o_m_data, mon_e.data);
              check("out_idx", o_m_idx, mon_e.idx);
              check("out_last", o_m_last, mon_e.last);
            end
            out_cnt++;
            if (o_m_idx == 4'd15) last_hs_cyc = cyc;
          end
        end
        prev_valid = o_m_valid;
        prev_stall = o_m_valid && !i_m_ready;
        prev_data  = o_m_data;
        prev_idx   = o_m_idx;
      end
    end
  end

  // Drives one symbol; called just after a rising edge. Checks start latency and held FFT inputs.
  task automatic send_symbol(input int nb, input bit lst, input int base, input bit stray);
    logic [511:0] exp_flat;
    logic [15:0]  re;
    int           guard;
    exp_flat = '0;
    for (int b = 0; b < nb; b++) begin
      re        = 16'(base + b);
      i_s_valid = 1'b1;
      i_s_data  = {re, -re};
      i_s_last  = lst && (b == nb - 1);
      exp_flat[b*32 +: 32] = {re, -re};
      guard = 0;
      @(negedge clk);
      while (!o_s_ready && guard < 400) begin
        guard++;
        @(negedge clk);
      end
      if (guard >= 400) bound_fail("s_ready_wait");
      if (b == 0) first_acc_cyc = cyc;
      if (stray && b == 1) stray_done = 1'b1;
      @(posedge clk);
      #1;
      stray_done = 1'b0;
    end
    i_s_valid = 1'b0;
    i_s_last  = 1'b0;
    @(negedge clk);
    sym_start_cyc = cyc;
    check("start_latency", o_fft_start, 1'b1);
    check("fft_in", o_fft_in, exp_flat);
  endtask

  task automatic wait_idle(input string name);
    int guard;
    guard = 0;
    @(negedge clk);
    while (o_busy && guard < 400) begin
      guard++;
      @(negedge clk);
    end
    if (guard >= 400) bound_fail(name);
  endtask

  initial begin : watchdog
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin : main
    int o0, s0, guard;
    vecs[0] = '{nb: 16, lst: 1, base: 0,   rmode: 0, delay: 5,  hang: 0, exp_nout: 16, exp_to: 0};
    vecs[1] = '{nb: 3,  lst: 1, base: 100, rmode: 0, delay: 5,  hang: 0, exp_nout: 16, exp_to: 0};
    vecs[2] = '{nb: 16, lst: 0, base: 200, rmode: 1, delay: 3,  hang: 0, exp_nout: 16, exp_to: 0};
    vecs[3] = '{nb: 16, lst: 1, base: 300, rmode: 0, delay: 5,  hang: 1, exp_nout: 0,  exp_to: 1};
    vecs[4] = '{nb: 1,  lst: 1, base: 400, rmode: 0, delay: 1,  hang: 0, exp_nout: 16, exp_to: 0};
    vecs[5] = '{nb: 16, lst: 1, base: -8,  rmode: 0, delay: 64, hang: 0, exp_nout: 16, exp_to: 0};

    i_rst      = 1'b1;
    i_s_valid  = 1'b0;
    i_s_last   = 1'b0;
    i_s_data   = '0;
    stray_done = 1'b0;
    stray_out  = {16{32'hDEADBEEF}};
    repeat (2) @(negedge clk);
    check("rst_s_ready", o_s_ready, 1'b1);
    check("rst_outputs", {o_m_valid, o_fft_start, o_busy, o_err_timeout, o_m_last, o_m_idx}, '0);
    check("rst_m_data", o_m_data, '0);
    check("rst_fft_in", o_fft_in, '0);
    @(posedge clk);
    #1;
    i_rst = 1'b0;

    for (int v = 0; v < 6; v++) begin
      hang       = vecs[v].hang;
      done_delay = vecs[v].delay;
      ready_mode = vecs[v].rmode;
      stalled    = 1'b0;
      o0 = out_cnt;
      s0 = start_cnt;
      @(posedge clk);
      #1;
      send_symbol(vecs[v].nb, vecs[v].lst, vecs[v].base, 1'b0);
      if (vecs[v].exp_to) begin
        guard = 0;
        @(negedge clk);
        while (!o_err_timeout && guard < 200) begin
          guard++;
          @(negedge clk);
        end
        if (guard >= 200) bound_fail("timeout_wait");
        check("timeout_cycle", cyc, sym_start_cyc + 65);
        check("timeout_idle", o_busy, 1'b0);
        @(negedge clk);
        check("timeout_pulse_width", o_err_timeout, 1'b0);
      end
      wait_idle("idle_wait");
      check("out_count", out_cnt - o0, vecs[v].exp_nout);
      check("start_count", start_cnt - s0, 1);
      check("queue_drained", exp_q.size(), 0);
    end

    // Back-to-back: second symbol offered as soon as the first starts unloading.
    hang = 0; done_delay = 5; ready_mode = 0;
    o0 = out_cnt;
    @(posedge clk);
    #1;
    send_symbol(16, 1'b1, 600, 1'b0);
    guard = 0;
    while (!o_m_valid && guard < 200) begin
      guard++;
      @(negedge clk);
    end
    if (guard >= 200) bound_fail("b2b_valid_wait");
    @(posedge clk);
    #1;
    send_symbol(16, 1'b1, 700, 1'b0);
    check("b2b_accept_cycle", first_acc_cyc, last_hs_cyc + 1);
    wait_idle("b2b_idle_wait");
    check("b2b_out_count", out_cnt - o0, 32);
    check("b2b_queue_drained", exp_q.size(), 0);

    // Stray done during LOAD, then asynchronous reset while bin 9 is presented.
    @(posedge clk);
    #1;
    send_symbol(16, 1'b1, 500, 1'b1);
    guard = 0;
    @(negedge clk);
    while (!(o_m_valid && o_m_idx == 4'd9) && guard < 200) begin
      guard++;
      @(negedge clk);
    end
    if (guard >= 200) bound_fail("abort_idx9_wait");
    #2;
    i_rst = 1'b1;
    exp_q.delete();
    @(negedge clk);
    check("abort_outputs", {o_m_valid, o_fft_start, o_busy, o_err_timeout, o_m_last, o_m_idx}, '0);
    check("abort_m_data", o_m_data, '0);
    check("abort_fft_in", o_fft_in, '0);
    check("abort_s_ready", o_s_ready, 1'b1);
    @(posedge clk);
    #1;
    i_rst = 1'b0;
    repeat (3) @(negedge clk);
    check("post_abort_idle", {o_busy, o_m_valid}, 2'b00);
    check("post_abort_s_ready", o_s_ready, 1'b1);

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
